// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: drains 16 bytes per word from the rx FIFO, checks the
// assembled word as a command frame (sync byte + 8-bit checksum) and presents it on a valid/ready port.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TO_CYCLES = 50000,
  parameter int         CNT_W     = 16
) (
  input  logic               clk_50mhz,
  input  logic               rst_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               word_done,
  input  logic [127:0]       word_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [7:0]         cmd_code,
  output logic [103:0]       cmd_payload,
  output logic               err_sync,
  output logic               err_csum,
  output logic               err_timeout,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int              TMR_W   = 20;
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(TO_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT_DONE, CHECK, OUT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [127:0]       word_q;
  logic               capture;
  logic               load_cmd;
  logic               cmd_valid_q, cmd_valid_d;
  logic [7:0]         cmd_code_q;
  logic [103:0]       cmd_payload_q;
  logic               err_sync_q, err_sync_d;
  logic               err_csum_q, err_csum_d;
  logic               err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               stalling;
  logic               timeout;
  logic               sync_ok;
  logic               csum_ok;

  function automatic logic csum_match(input logic [127:0] w);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 1; i < 16; i++) sum = sum + w[i*8 +: 8];
    return sum == w[7:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The timer only runs while waiting on the FIFO or the assembler; any read or exit clears it.
  assign stalling = ((state_q == READ) && fifo_empty) ||
                    ((state_q == WAIT_DONE) && !word_done);
  assign timeout  = stalling && (timer_q == TO_LAST);
  assign sync_ok  = (word_q[127:120] == SYNC_BYTE);
  assign csum_ok  = csum_match(word_q);

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!fifo_empty) state_d = READ;
      READ: begin
        if (timeout)                          state_d = IDLE;
        else if (fifo_rd_en && cnt_q == 4'd15) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout)        state_d = IDLE;
        else if (word_done) state_d = CHECK;
      end
      CHECK:     state_d = (sync_ok && csum_ok) ? OUT : IDLE;
      OUT:       if (cmd_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en    = (state_q == READ) && !fifo_empty;
    cnt_d         = cnt_q;
    timer_d       = '0;
    capture       = 1'b0;
    load_cmd      = 1'b0;
    cmd_valid_d   = cmd_valid_q;
    err_sync_d    = 1'b0;
    err_csum_d    = 1'b0;
    err_timeout_d = timeout;
    frame_cnt_d   = frame_cnt_q;
    if (stalling && !timeout) timer_d = timer_q + 1'b1;
    unique case (state_q)
      IDLE:      cnt_d = 4'd0;
      READ: begin
        if (timeout)         cnt_d = 4'd0;
        else if (fifo_rd_en) cnt_d = cnt_q + 4'd1;
      end
      WAIT_DONE: capture = word_done;
      CHECK: begin
        // A bad sync byte masks the checksum result.
        err_sync_d = !sync_ok;
        err_csum_d = sync_ok && !csum_ok;
        if (sync_ok && csum_ok) begin
          load_cmd    = 1'b1;
          cmd_valid_d = 1'b1;
        end
      end
      OUT: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          frame_cnt_d = sat_inc(frame_cnt_q);
        end
      end
      default: ;
    endcase
    err_cnt_d = (err_sync_d || err_csum_d || err_timeout_d) ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      timer_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      cmd_payload_q <= '0;
      err_sync_q    <= 1'b0;
      err_csum_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      cmd_valid_q   <= cmd_valid_d;
      err_sync_q    <= err_sync_d;
      err_csum_q    <= err_csum_d;
      err_timeout_q <= err_timeout_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
      if (load_cmd) begin
        cmd_code_q    <= word_q[119:112];
        cmd_payload_q <= word_q[111:8];
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (capture) word_q <= word_data;
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign cmd_payload = cmd_payload_q;
  assign err_sync    = err_sync_q;
  assign err_csum    = err_csum_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a byte FIFO and 8->128 assembler model.
module tb_uart_rx_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_rd_en;
  logic         word_done;
  logic [127:0] word_data;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_code;
  logic [103:0] cmd_payload;
  logic         err_sync;
  logic         err_csum;
  logic         err_timeout;
  logic [15:0]  frame_cnt;
  logic [15:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  uart_rx_frame_ctrl #(.SYNC_BYTE(8'hA5), .TO_CYCLES(8), .CNT_W(16)) dut (
    .clk_50mhz  (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .word_done  (word_done),
    .word_data  (word_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_payload(cmd_payload),
    .err_sync   (err_sync),
    .err_csum   (err_csum),
    .err_timeout(err_timeout),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  // Byte FIFO model: the initial block writes, the clocked monitor pops.
  logic [7:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  logic hold_done = 1'b0;
  logic [127:0] asm_sh;
  int asm_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_n     <= 0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (fifo_rd_en) begin
        asm_sh <= {asm_sh[119:0], fmem[rd_ptr]};
        if (asm_n == 15) begin
          asm_n     <= 0;
          word_data <= {asm_sh[119:0], fmem[rd_ptr]};
          word_done <= !hold_done;
        end else begin
          asm_n <= asm_n + 1;
        end
      end
    end
  end

  int cyc = 0, rd_total = 0, viol = 0;
  int sync_hi = 0, csum_hi = 0, to_hi = 0, valid_hi = 0;
  int wd_cyc = 0, vr_cyc = 0, rd_last = 0, to_cyc = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    valid_prev <= cmd_valid;
    if (fifo_rd_en) begin
      rd_ptr   <= rd_ptr + 1;
      rd_total <= rd_total + 1;
      rd_last  <= cyc;
      if (fifo_empty) viol <= viol + 1;
    end
    if (word_done)              wd_cyc   <= cyc;
    if (cmd_valid && !valid_prev) vr_cyc <= cyc;
    if (cmd_valid)              valid_hi <= valid_hi + 1;
    if (err_sync)               sync_hi  <= sync_hi + 1;
    if (err_csum)               csum_hi  <= csum_hi + 1;
    if (err_timeout) begin
      to_hi  <= to_hi + 1;
      to_cyc <= cyc;
    end
  end

  localparam logic [127:0] GOOD1  = {8'hA5, 8'h01, 104'h0, 8'hA6};
  localparam logic [127:0] BADSYN = {8'h5A, 8'h01, 104'h0, 8'h5B};
  localparam logic [127:0] WRAP   = {8'hA5, 8'hFF, {13{8'h01}}, 8'hB1};
  localparam logic [127:0] WRAPB  = {8'hA5, 8'hFF, {13{8'h01}}, 8'hB2};
  localparam logic [127:0] BPF    = {8'hA5, 8'h3C, 104'h0102030405060708090A0B0C0D, 8'h3C};

  task automatic push_bytes(input logic [127:0] f, input int nbytes);
    for (int i = 15; i > 15 - nbytes; i--) begin
      fmem[wr_ptr] = f[i*8 +: 8];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_valid(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({fifo_rd_en, cmd_valid, err_sync, err_csum, err_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {fifo_rd_en, cmd_valid, err_sync, err_csum, err_timeout});
    end
    n_chk++;
    if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: frame_cnt=%0d err_cnt=%0d expected 0 0", frame_cnt, err_cnt);
    end
    n_chk++;
    if (cmd_code !== 8'h00 || cmd_payload !== 104'h0) begin
      n_fail++;
      $display("FAIL reset_fields: code=%h payload=%h expected 0", cmd_code, cmd_payload);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_read: rd_en=%b expected 0", fifo_rd_en);
    end
  endtask

  task automatic test_good_frame;
    bit got;
    int rd0, sy0, cs0;
    rd0 = rd_total; sy0 = sync_hi; cs0 = csum_hi;
    cmd_ready = 1'b1;
    push_bytes(GOOD1, 16);
    wait_valid(40, got);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL good_valid: cmd_valid never rose, expected 1");
    end
    n_chk++;
    if (cmd_code !== 8'h01 || cmd_payload !== 104'h0) begin
      n_fail++;
      $display("FAIL good_fields: code=%h payload=%h expected 01 0", cmd_code, cmd_payload);
    end
    @(negedge clk);
    n_chk++;
    if (cmd_valid !== 1'b0 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL good_handshake: valid=%b frame_cnt=%0d expected 0 1", cmd_valid, frame_cnt);
    end
    n_chk++;
    if (rd_total - rd0 != 16) begin
      n_fail++;
      $display("FAIL good_reads: %0d reads expected 16", rd_total - rd0);
    end
    n_chk++;
    if (vr_cyc - wd_cyc != 2) begin
      n_fail++;
      $display("FAIL good_latency: %0d cycles expected 2", vr_cyc - wd_cyc);
    end
    n_chk++;
    if (sync_hi != sy0 || csum_hi != cs0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL good_no_err: sync=%0d csum=%0d err_cnt=%0d expected none", sync_hi - sy0, csum_hi - cs0, err_cnt);
    end
  endtask

  task automatic test_sync_err;
    bit got;
    int sy0, cs0, v0;
    sy0 = sync_hi; cs0 = csum_hi; v0 = valid_hi;
    push_bytes(BADSYN, 16);
    repeat (30) @(negedge clk);
    n_chk++;
    if (sync_hi - sy0 != 1 || csum_hi != cs0) begin
      n_fail++;
      $display("FAIL sync_pulse: sync cycles=%0d csum cycles=%0d expected 1 0", sync_hi - sy0, csum_hi - cs0);
    end
    n_chk++;
    if (err_cnt !== 16'd1 || valid_hi != v0) begin
      n_fail++;
      $display("FAIL sync_effect: err_cnt=%0d valid cycles=%0d expected 1 0", err_cnt, valid_hi - v0);
    end
    push_bytes(GOOD1, 16);
    wait_valid(40, got);
    @(negedge clk);
    n_chk++;
    if (!got || frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL sync_recover: got=%0d frame_cnt=%0d expected 1 2", got, frame_cnt);
    end
  endtask

  task automatic test_csum_wrap;
    bit got;
    int cs0, v0;
    push_bytes(WRAP, 16);
    wait_valid(40, got);
    n_chk++;
    if (!got || cmd_code !== 8'hFF || cmd_payload !== {13{8'h01}}) begin
      n_fail++;
      $display("FAIL wrap_accept: got=%0d code=%h payload=%h expected 1 ff 0101..01", got, cmd_code, cmd_payload);
    end
    @(negedge clk);
    n_chk++;
    if (frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL wrap_count: frame_cnt=%0d expected 3", frame_cnt);
    end
    cs0 = csum_hi; v0 = valid_hi;
    push_bytes(WRAPB, 16);
    repeat (30) @(negedge clk);
    n_chk++;
    if (csum_hi - cs0 != 1 || err_cnt !== 16'd2 || valid_hi != v0) begin
      n_fail++;
      $display("FAIL csum_err: csum cycles=%0d err_cnt=%0d valid cycles=%0d expected 1 2 0", csum_hi - cs0, err_cnt, valid_hi - v0);
    end
  endtask

  task automatic test_backpressure;
    bit got;
    int rd0, unstable;
    cmd_ready = 1'b0;
    push_bytes(BPF, 16);
    push_bytes(GOOD1, 16);
    wait_valid(40, got);
    n_chk++;
    if (!got || cmd_code !== 8'h3C || cmd_payload !== 104'h0102030405060708090A0B0C0D) begin
      n_fail++;
      $display("FAIL bp_fields: got=%0d code=%h payload=%h", got, cmd_code, cmd_payload);
    end
    rd0 = rd_total;
    unstable = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_code !== 8'h3C || cmd_payload !== 104'h0102030405060708090A0B0C0D)
        unstable++;
    end
    n_chk++;
    if (unstable != 0 || rd_total != rd0) begin
      n_fail++;
      $display("FAIL bp_hold: unstable cycles=%0d reads=%0d expected 0 0", unstable, rd_total - rd0);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cmd_valid !== 1'b0 || fifo_rd_en !== 1'b0 || frame_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b rd_en=%b frame_cnt=%0d expected 0 0 4", cmd_valid, fifo_rd_en, frame_cnt);
    end
    @(negedge clk);
    n_chk++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume: rd_en=%b expected 1 two cycles after handshake", fifo_rd_en);
    end
    wait_valid(40, got);
    @(negedge clk);
    n_chk++;
    if (!got || frame_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_next: got=%0d frame_cnt=%0d expected 1 5", got, frame_cnt);
    end
  endtask

  task automatic test_timeout;
    int to0, rd0, bad_rd;
    bit seen;
    to0 = to_hi; rd0 = rd_total;
    bad_rd = 0; seen = 1'b0;
    push_bytes(GOOD1, 7);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (rd_total - rd0 == 7 && fifo_rd_en) bad_rd++;
      if (err_timeout) seen = 1'b1;
    end
    n_chk++;
    if (!seen || rd_total - rd0 != 7 || bad_rd != 0) begin
      n_fail++;
      $display("FAIL timeout_pulse: seen=%0d reads=%0d stall reads=%0d expected 1 7 0", seen, rd_total - rd0, bad_rd);
    end
    @(negedge clk);
    // Launched 8 edges after the last read edge, so first sampled high on the 9th.
    n_chk++;
    if (to_cyc - rd_last != 9 || to_hi - to0 != 1) begin
      n_fail++;
      $display("FAIL timeout_timing: delay=%0d width=%0d expected 9 1", to_cyc - rd_last, to_hi - to0);
    end
    n_chk++;
    if (err_cnt !== 16'd3 || fifo_rd_en !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: err_cnt=%0d rd_en=%b valid=%b expected 3 0 0", err_cnt, fifo_rd_en, cmd_valid);
    end
  endtask

  task automatic test_reset_wait_done;
    bit got;
    int rd0;
    rd0 = rd_total;
    hold_done = 1'b1;
    push_bytes(GOOD1, 16);
    for (int i = 0; i < 40 && rd_total - rd0 < 16; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_chk++;
    if (frame_cnt !== 16'd0 || err_cnt !== 16'd0 || cmd_code !== 8'h00 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: frame_cnt=%0d err_cnt=%0d code=%h rd_en=%b expected 0 0 00 0", frame_cnt, err_cnt, cmd_code, fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    hold_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push_bytes(GOOD1, 16);
    wait_valid(40, got);
    @(negedge clk);
    n_chk++;
    if (!got || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset: got=%0d frame_cnt=%0d expected 1 1", got, frame_cnt);
    end
    n_chk++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL rd_when_empty: %0d reads while empty expected 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_sync_err();
    test_csum_wrap();
    test_backpressure();
    test_timeout();
    test_reset_wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
